alsu_arbiter: RTL

//  Shares one ALSU instance between two requesters (r0, r1).
//  Per operation: round-robin grant, operand/control capture, ALSU drive, pipeline-latency wait,

---
 rtl/alsu_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/alsu_arbiter.sv
// -----------------------------------------------------------------------------
// alsu_arbiter
//
// Shares a single ALSU between two requesters (r0, r1). Each operation:
// round-robin grant, operand/control capture onto the ALSU inputs, a wait
// covering the ALSU pipeline latency, capture of the ALSU result and error
// leds, and return of a response that is held until it is consumed.
//
// Parameters
//   ALSU_LATENCY  edges from an ALSU input change to its registered out/leds (1..15)
//   LAT_W         width of the latency wait counter (must hold ALSU_LATENCY)
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   r0_valid/ready/cmd       requester 0 handshake and 15-bit command
//   r1_valid/ready/cmd       requester 1 handshake and 15-bit command
//                            cmd = {opcode[2:0],A[2:0],B[2:0],cin,serial_in,
//                                   direction,red_op_A,red_op_B,1'b0}
//   rsp_valid/ready          response handshake
//   rsp_id                   requester the response belongs to
//   rsp_data, rsp_err        captured ALSU out and (ALSU leds != 0)
//   alsu_*                   ALSU input drive (bypass_A/bypass_B tied low)
//   alsu_out, alsu_leds      ALSU result and status leds
//
// Optional feature: define ALSU_ARB_STATS_EN to add the saturating response
// counters stat_ops[15:0] and stat_errs[15:0].
// -----------------------------------------------------------------------------
module alsu_arbiter #(
    parameter int ALSU_LATENCY = 2,
    parameter int LAT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [14:0] r0_cmd,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [14:0] r1_cmd,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [5:0]  rsp_data,
    output logic        rsp_err,
    output logic [2:0]  alsu_A,
    output logic [2:0]  alsu_B,
    output logic [2:0]  alsu_opcode,
    output logic        alsu_cin,
    output logic        alsu_serial_in,
    output logic        alsu_direction,
    output logic        alsu_red_op_A,
    output logic        alsu_red_op_B,
    output logic        alsu_bypass_A,
    output logic        alsu_bypass_B,
    input  logic [5:0]  alsu_out,
    input  logic [15:0] alsu_leds
`ifdef ALSU_ARB_STATS_EN
    ,
    output logic [15:0] stat_ops,
    output logic [15:0] stat_errs
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [LAT_W-1:0]   cnt;
    logic               last_grant;
    logic               grant_r0;
    logic               grant_r1;
    logic               accept;
    logic [14:0]        sel_cmd;
    logic               rsp_hs;

    // The always-zero LSB of each command carries no information.
    logic               unused_cmd_lsb;
    assign unused_cmd_lsb = r0_cmd[0] ^ r1_cmd[0];

    assign alsu_bypass_A = 1'b0;
    assign alsu_bypass_B = 1'b0;

    // last_grant == 1 means r1 was served last, so r0 wins a tie.
    always_comb begin
        grant_r0 = r0_valid & (~r1_valid | last_grant);
        grant_r1 = r1_valid & (~r0_valid | ~last_grant);
        r0_ready = (state == IDLE) & grant_r0;
        r1_ready = (state == IDLE) & grant_r1;
        accept   = r0_ready | r1_ready;
        sel_cmd  = r1_ready ? r1_cmd : r0_cmd;
        rsp_hs   = rsp_valid & rsp_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = WAIT;
            WAIT: if (cnt == '0) state_nx = CAPT;
            CAPT: state_nx = RESP;
            RESP: if (rsp_hs) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt            <= '0;
            last_grant     <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_id         <= 1'b0;
            rsp_data       <= '0;
            rsp_err        <= 1'b0;
            alsu_A         <= '0;
            alsu_B         <= '0;
            alsu_opcode    <= '0;
            alsu_cin       <= 1'b0;
            alsu_serial_in <= 1'b0;
            alsu_direction <= 1'b0;
            alsu_red_op_A  <= 1'b0;
            alsu_red_op_B  <= 1'b0;
        end else begin
            case (state)
                // Accept edge: launch the command onto the ALSU and start the wait.
                IDLE: begin
                    if (accept) begin
                        alsu_opcode    <= sel_cmd[14:12];
                        alsu_A         <= sel_cmd[11:9];
                        alsu_B         <= sel_cmd[8:6];
                        alsu_cin       <= sel_cmd[5];
                        alsu_serial_in <= sel_cmd[4];
                        alsu_direction <= sel_cmd[3];
                        alsu_red_op_A  <= sel_cmd[2];
                        alsu_red_op_B  <= sel_cmd[1];
                        rsp_id         <= r1_ready;
                        last_grant     <= r1_ready;
                        cnt            <= LAT_W'(ALSU_LATENCY);
                    end
                end
                // ALSU pipeline wait: inputs held, counter runs down to zero.
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - LAT_W'(1);
                    end
                end
                // Result capture from the settled ALSU outputs.
                CAPT: begin
                    rsp_data  <= alsu_out;
                    rsp_err   <= |alsu_leds;
                    rsp_valid <= 1'b1;
                end
                // Response held until consumed.
                RESP: begin
                    if (rsp_hs) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALSU_ARB_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_ops  <= '0;
            stat_errs <= '0;
        end else if (rsp_hs) begin
            stat_ops <= sat_inc(stat_ops);
            if (rsp_err) begin
                stat_errs <= sat_inc(stat_errs);
            end
        end
    end
`endif

endmodule
